// File: rtl/dice_roll_sequencer.sv
// Roll-button conditioner, dice counters and win/loss tally sitting in front of the dice-game FSM.
// Turns a raw press into a minimum-width Rb_o pulse and sequences the per-game Reset_o pulse.
module dice_roll_sequencer #(
    parameter int MIN_ROLL_CYC = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_i,
    input  logic             new_game_i,
    input  logic             roll_i,
    input  logic             win_i,
    input  logic             lose_i,
    output logic             Rb_o,
    output logic             Reset_o,
    output logic [3:0]       sum_o,
    output logic [2:0]       die1_o,
    output logic [2:0]       die2_o,
    output logic             game_over_o,
    output logic [CNT_W-1:0] win_cnt_o,
    output logic [CNT_W-1:0] lose_cnt_o
);

    // state   | meaning
    // IDLE    | waiting for a roll request
    // PRESS   | Rb_o high, dice advancing while roll_i
    // SETTLE  | Rb_o low, dice frozen, waiting for a result or a point roll
    // RESULT  | game over, waiting for new_game_i
    // CLEAR   | one-cycle Reset_o to the game FSM
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS  = 3'd1,
        SETTLE = 3'd2,
        RESULT = 3'd3,
        CLEAR  = 3'd4
    } state_t;

    localparam int HOLD_W = $clog2(MIN_ROLL_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_ROLL_CYC);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [2:0]        die1_nxt;
    logic [2:0]        die2_nxt;
    logic              press_done;

    // hold_nxt counts the current PRESS cycle, so the pulse is exactly MIN_ROLL_CYC wide on early release
    always_comb begin
        hold_nxt   = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);
        press_done = !btn_i && (hold_nxt == HOLD_MAX);
        die1_nxt   = (die1_o == 3'd6) ? 3'd1 : die1_o + 3'd1;
        die2_nxt   = die2_o;
        if (die1_o == 3'd6) begin
            die2_nxt = (die2_o == 3'd6) ? 3'd1 : die2_o + 3'd1;
        end
    end

    assign sum_o = {1'b0, die1_o} + {1'b0, die2_o};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            Rb_o        <= 1'b0;
            Reset_o     <= 1'b0;
            game_over_o <= 1'b0;
            die1_o      <= 3'd1;
            die2_o      <= 3'd1;
            win_cnt_o   <= '0;
            lose_cnt_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_i) begin
                        state    <= PRESS;
                        hold_cnt <= '0;
                        Rb_o     <= 1'b1;
                    end
                end
                PRESS: begin
                    hold_cnt <= hold_nxt;
                    if (roll_i) begin
                        die1_o <= die1_nxt;
                        die2_o <= die2_nxt;
                    end
                    if (press_done) begin
                        state <= SETTLE;
                        Rb_o  <= 1'b0;
                    end
                end
                SETTLE: begin
                    // a result flag outranks a simultaneous point-roll request
                    if (win_i || lose_i) begin
                        state       <= RESULT;
                        game_over_o <= 1'b1;
                        if (win_i) begin
                            if (win_cnt_o != '1) win_cnt_o <= win_cnt_o + CNT_W'(1);
                        end else begin
                            if (lose_cnt_o != '1) lose_cnt_o <= lose_cnt_o + CNT_W'(1);
                        end
                    end else if (btn_i) begin
                        state    <= PRESS;
                        hold_cnt <= '0;
                        Rb_o     <= 1'b1;
                    end
                end
                RESULT: begin
                    if (new_game_i) begin
                        state       <= CLEAR;
                        game_over_o <= 1'b0;
                        Reset_o     <= 1'b1;
                        die1_o      <= 3'd1;
                        die2_o      <= 3'd1;
                    end
                end
                CLEAR: begin
                    state   <= IDLE;
                    Reset_o <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    Rb_o        <= 1'b0;
                    Reset_o     <= 1'b0;
                    game_over_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// Directed bench for dice_roll_sequencer: press width, die wrap, results, tally saturation, reset.
module tb_dice_roll_sequencer;

    localparam int MIN_ROLL_CYC = 4;
    localparam int CNT_W        = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             btn_i;
    logic             new_game_i;
    logic             roll_i;
    logic             win_i;
    logic             lose_i;
    logic             Rb_o;
    logic             Reset_o;
    logic [3:0]       sum_o;
    logic [2:0]       die1_o;
    logic [2:0]       die2_o;
    logic             game_over_o;
    logic [CNT_W-1:0] win_cnt_o;
    logic [CNT_W-1:0] lose_cnt_o;

    int n_checks = 0;
    int n_errors = 0;
    int rb_width;

    dice_roll_sequencer #(.MIN_ROLL_CYC(MIN_ROLL_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .btn_i(btn_i), .new_game_i(new_game_i), .roll_i(roll_i),
        .win_i(win_i), .lose_i(lose_i), .Rb_o(Rb_o), .Reset_o(Reset_o), .sum_o(sum_o),
        .die1_o(die1_o), .die2_o(die2_o), .game_over_o(game_over_o),
        .win_cnt_o(win_cnt_o), .lose_cnt_o(lose_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // one active edge, then outputs settle and inputs may change
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // single-cycle press from IDLE/SETTLE, lands in SETTLE after MIN_ROLL_CYC cycles of Rb_o
    task automatic press_short();
        btn_i = 1'b1;
        step();
        btn_i = 1'b0;
        repeat (MIN_ROLL_CYC) step();
    endtask

    task automatic finish_game(input logic w, input logic l);
        win_i  = w;
        lose_i = l;
        step();
        win_i      = 1'b0;
        lose_i     = 1'b0;
        new_game_i = 1'b1;
        step();
        new_game_i = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; btn_i = 1'b0; new_game_i = 1'b0; roll_i = 1'b0; win_i = 1'b0; lose_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_rb", Rb_o, 0);
        check("reset_reset_o", Reset_o, 0);
        check("reset_game_over", game_over_o, 0);
        check("reset_die1", die1_o, 1);
        check("reset_die2", die2_o, 1);
        check("reset_sum", sum_o, 2);
        check("reset_win_cnt", win_cnt_o, 0);
        check("reset_lose_cnt", lose_cnt_o, 0);

        // early release: one-cycle press still yields a 4-cycle Rb_o
        roll_i = 1'b1;
        btn_i  = 1'b1;
        step();
        btn_i    = 1'b0;
        rb_width = 0;
        for (int i = 0; i < 20 && Rb_o; i++) begin
            rb_width++;
            step();
        end
        check("min_width", rb_width, 4);
        check("min_width_rb_low", Rb_o, 0);
        check("early_die1", die1_o, 5);
        check("early_die2", die2_o, 1);
        check("early_sum", sum_o, 6);

        // win from SETTLE, btn ignored in RESULT, then new game
        win_i = 1'b1;
        step();
        win_i = 1'b0;
        check("win_game_over", game_over_o, 1);
        check("win_cnt_1", win_cnt_o, 1);
        check("win_lose_cnt", lose_cnt_o, 0);
        btn_i = 1'b1;
        step();
        btn_i = 1'b0;
        check("result_btn_ignored_rb", Rb_o, 0);
        check("result_btn_ignored_go", game_over_o, 1);
        new_game_i = 1'b1;
        step();
        new_game_i = 1'b0;
        check("clear_reset_o", Reset_o, 1);
        check("clear_game_over", game_over_o, 0);
        check("clear_die1", die1_o, 1);
        check("clear_die2", die2_o, 1);
        check("clear_sum", sum_o, 2);
        step();
        check("idle_reset_o_low", Reset_o, 0);
        check("idle_rb_low", Rb_o, 0);

        // die wrap: 6 advancing cycles from (1,1)
        btn_i = 1'b1;
        repeat (6) step();
        check("wrap_rb_high", Rb_o, 1);
        btn_i = 1'b0;
        step();
        check("wrap_rb_low", Rb_o, 0);
        check("wrap_die1", die1_o, 1);
        check("wrap_die2", die2_o, 2);
        check("wrap_sum", sum_o, 3);

        // point roll from SETTLE: 30 more cycles completes the period of 36
        btn_i = 1'b1;
        step();
        check("point_roll_rb", Rb_o, 1);
        repeat (29) step();
        btn_i = 1'b0;
        step();
        check("period_rb_low", Rb_o, 0);
        check("period_die1", die1_o, 1);
        check("period_die2", die2_o, 1);
        check("period_sum", sum_o, 2);

        // dice hold in SETTLE despite roll_i
        step();
        check("settle_hold_die1", die1_o, 1);

        // win and btn together in SETTLE: RESULT wins, Rb_o stays low
        win_i = 1'b1;
        btn_i = 1'b1;
        step();
        win_i = 1'b0;
        check("simul_game_over", game_over_o, 1);
        check("simul_rb", Rb_o, 0);
        check("simul_win_cnt", win_cnt_o, 2);
        // btn held through RESULT/CLEAR only starts a roll once IDLE samples it
        new_game_i = 1'b1;
        step();
        new_game_i = 1'b0;
        check("held_btn_clear_rb", Rb_o, 0);
        check("held_btn_clear_reset", Reset_o, 1);
        step();
        check("held_btn_idle_rb", Rb_o, 0);
        step();
        check("held_btn_press_rb", Rb_o, 1);
        btn_i = 1'b0;
        repeat (MIN_ROLL_CYC) step();
        check("held_btn_settle_rb", Rb_o, 0);

        // win and lose together: win has priority, then win tally saturates
        finish_game(1'b1, 1'b1);
        check("both_flags_win_cnt", win_cnt_o, 3);
        check("both_flags_lose_cnt", lose_cnt_o, 0);
        press_short();
        finish_game(1'b1, 1'b0);
        check("win_saturate", win_cnt_o, 3);

        // five losses saturate the 2-bit lose tally
        for (int g = 1; g <= 5; g++) begin
            press_short();
            finish_game(1'b0, 1'b1);
            check($sformatf("lose_game_%0d", g), lose_cnt_o, (g > 3) ? 3 : g);
        end
        check("lose_sat_win_cnt", win_cnt_o, 3);

        // new_game_i outside RESULT is ignored
        new_game_i = 1'b1;
        step();
        check("ng_idle_reset_o", Reset_o, 0);
        new_game_i = 1'b0;
        press_short();
        new_game_i = 1'b1;
        step();
        new_game_i = 1'b0;
        check("ng_settle_reset_o", Reset_o, 0);
        check("ng_settle_game_over", game_over_o, 0);

        // reset mid-press aborts
        win_i = 1'b1;
        step();
        win_i      = 1'b0;
        new_game_i = 1'b1;
        step();
        new_game_i = 1'b0;
        step();
        btn_i = 1'b1;
        step();
        step();
        check("pre_reset_rb", Rb_o, 1);
        rst   = 1'b1;
        btn_i = 1'b0;
        step();
        rst = 1'b0;
        check("midpress_rb", Rb_o, 0);
        check("midpress_win_cnt", win_cnt_o, 0);
        check("midpress_lose_cnt", lose_cnt_o, 0);
        check("midpress_sum", sum_o, 2);
        step();
        check("midpress_stays_idle", Rb_o, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
